// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// l2_arbiter: shares one l2_cache port between the I-cache and the D-cache
// Revision: 1.0
// ============================================================================
module l2_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_read,
    input  logic [15:0]  i_address,
    output logic         i_resp,
    output logic [127:0] i_rdata,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_address,
    input  logic [127:0] d_wdata,
    output logic         d_resp,
    output logic [127:0] d_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [15:0]  mem_address,
    output logic [127:0] mem_wdata,
    input  logic         mem_resp,
    input  logic [127:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t state;
    logic   last_d;
    logic   i_req;
    logic   d_req;
    logic   tie_to_d;
    logic   grant_d;
    logic   grant_i;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // On a tie, round-robin hands the bus to whichever port was not served last.
    assign tie_to_d = (ROUND_ROBIN != 0) ? ~last_d : 1'b1;
    assign grant_d  = d_req & (~i_req | tie_to_d);
    assign grant_i  = i_req & ~grant_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            last_d      <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (grant_d) begin
                        state       <= SERVE_D;
                        mem_read    <= d_read & ~d_write;
                        mem_write   <= d_write;
                        mem_address <= d_address;
                        mem_wdata   <= d_wdata;
                    end else if (grant_i) begin
                        state       <= SERVE_I;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_address <= i_address;
                    end else begin
                        state       <= IDLE;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    // The GAP cycle stops l2_cache from re-sampling a request it just finished.
                    if (mem_resp) begin
                        state     <= GAP;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        last_d    <= (state == SERVE_D);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign i_resp  = (state == SERVE_I) & mem_resp;
    assign d_resp  = (state == SERVE_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule
`default_nettype wire
